// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one registered bitwise logic unit
// Optional grant counter enabled by defining LGU_ARB_GRANT_CNT_EN.
module logic_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*3-1:0]     req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [IDW-1:0]           resp_id,
    output logic                     resp_err
`ifdef LGU_ARB_GRANT_CNT_EN
    ,
    output logic [15:0]              grant_cnt
`endif
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_state_t;

    slot_state_t      state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic             resp_err_q, resp_err_d;

    logic             slot_free;
    logic             found;
    logic [IDW-1:0]   winner;
    logic             accept;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] result;
    logic             result_err;

    assign slot_free = (state_q == S_EMPTY) || resp_ready;

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int idx_int;
        logic [IDW-1:0] idx;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_int = int'(rr_ptr_q) + i;
            if (idx_int >= NUM_REQ) begin
                idx_int = idx_int - NUM_REQ;
            end
            idx = IDW'(idx_int);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Gated by rst_n so no requester sees a grant while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && found && slot_free) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    assign sel_op = req_op[3*winner +: 3];
    assign sel_a  = req_a[WIDTH*winner +: WIDTH];
    assign sel_b  = req_b[WIDTH*winner +: WIDTH];

    always_comb begin
        result     = '0;
        result_err = 1'b0;
        case (sel_op)
            3'd0:    result = sel_a & sel_b;
            3'd1:    result = sel_a | sel_b;
            3'd2:    result = ~sel_a;
            3'd3:    result = ~(sel_a & sel_b);
            3'd4:    result = ~(sel_a | sel_b);
            3'd5:    result = sel_a ^ sel_b;
            3'd6:    result = ~(sel_a ^ sel_b);
            default: result_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (accept) state_d = S_FULL;
            S_FULL:  if (!accept && resp_ready) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        resp_valid = (state_q == S_FULL);
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        resp_err_d  = resp_err_q;
        if (accept) begin
            rr_ptr_d    = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            resp_data_d = result;
            resp_id_d   = winner;
            resp_err_d  = result_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign resp_data = resp_data_q;
    assign resp_id   = resp_id_q;
    assign resp_err  = resp_err_q;

`ifdef LGU_ARB_GRANT_CNT_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (accept && grant_cnt_q != 16'hFFFF) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - directed self-checking bench for logic_unit_arbiter
// Counter checks are included when LGU_ARB_GRANT_CNT_EN is defined.
module tb_logic_unit_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int IDW     = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*3-1:0]     req_op;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [WIDTH-1:0]         resp_data;
    logic [IDW-1:0]           resp_id;
    logic                     resp_err;
`ifdef LGU_ARB_GRANT_CNT_EN
    logic [15:0]              grant_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic_unit_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err)
`ifdef LGU_ARB_GRANT_CNT_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*i +: 3]     = op;
        req_a[WIDTH*i +: WIDTH] = a;
        req_b[WIDTH*i +: WIDTH] = b;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [1:0] fair_id   [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] fair_data [6] = '{8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h1E, 8'h2D};
    logic [7:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        @(negedge clk);
        #1;
        check_eq("reset_req_ready", 32'(req_ready), 32'h0);
        check_eq("reset_valid", 32'(resp_valid), 32'h0);
        check_eq("reset_data", 32'(resp_data), 32'h0);
        check_eq("reset_id", 32'(resp_id), 32'h0);
        check_eq("reset_err", 32'(resp_err), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 2
        set_req(2, 3'd5, 8'hF0, 8'h3C);
        req_valid = 4'b0100;
        #1;
        check_eq("single_req_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        check_eq("single_valid", 32'(resp_valid), 32'h1);
        check_eq("single_data", 32'(resp_data), 32'hCC);
        check_eq("single_id", 32'(resp_id), 32'h2);
        check_eq("single_err", 32'(resp_err), 32'h0);
        step();
        check_eq("drain_valid", 32'(resp_valid), 32'h0);

        // Asynchronous reset while a result is held
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'd5, 8'(8'h11 * (i + 1)), 8'h0F);
        req_valid = 4'b1111;
        #1;
        check_eq("pre_reset_ready", 32'(req_ready), 32'h8);
        step();
        check_eq("pre_reset_valid", 32'(resp_valid), 32'h1);
        check_eq("pre_reset_data", 32'(resp_data), 32'h4B);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(resp_valid), 32'h0);
        check_eq("async_rst_data", 32'(resp_data), 32'h0);
        check_eq("async_rst_id", 32'(resp_id), 32'h0);
        check_eq("async_rst_err", 32'(resp_err), 32'h0);
        check_eq("async_rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness with all requesters active, including pointer wrap
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq($sformatf("fair_ready_%0d", k), 32'(req_ready), 32'(4'b0001 << fair_id[k]));
            step();
            check_eq($sformatf("fair_valid_%0d", k), 32'(resp_valid), 32'h1);
            check_eq($sformatf("fair_id_%0d", k), 32'(resp_id), 32'(fair_id[k]));
            check_eq($sformatf("fair_data_%0d", k), 32'(resp_data), 32'(fair_data[k]));
        end

        // Backpressure: lone requester 0 wins although rr_ptr is 2
        set_req(0, 3'd0, 8'hFF, 8'h0F);
        req_valid = 4'b0001;
        #1;
        check_eq("lone_ready", 32'(req_ready), 32'h1);
        step();
        resp_ready = 1'b0;
        set_req(1, 3'd1, 8'hF0, 8'h0F);
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'h0);
            check_eq($sformatf("bp_valid_%0d", k), 32'(resp_valid), 32'h1);
            check_eq($sformatf("bp_data_%0d", k), 32'(resp_data), 32'h0F);
            check_eq($sformatf("bp_id_%0d", k), 32'(resp_id), 32'h0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        check_eq("bp_new_data", 32'(resp_data), 32'hFF);
        check_eq("bp_new_id", 32'(resp_id), 32'h1);

        // Opcode sweep on requester 3
        req_valid = 4'b1000;
        for (int op = 0; op < 8; op++) begin
            set_req(3, 3'(op), 8'hA5, 8'h0F);
            step();
            check_eq($sformatf("op%0d_data", op), 32'(resp_data), 32'(sweep_exp[op]));
            check_eq($sformatf("op%0d_err", op), 32'(resp_err), (op == 7) ? 32'h1 : 32'h0);
            check_eq($sformatf("op%0d_id", op), 32'(resp_id), 32'h3);
        end
        req_valid = '0;
        step();
        check_eq("final_drain", 32'(resp_valid), 32'h0);

`ifdef LGU_ARB_GRANT_CNT_EN
        rst_n = 1'b0;
        #1;
        check_eq("cnt_reset", 32'(grant_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) step();
        req_valid = '0;
        step();
        check_eq("cnt_ten", 32'(grant_cnt), 32'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one registered bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) among several requesters. Each cycle it grants at most one valid requester and executes that requester's opcode on its operands. The result is returned through a single response channel with valid/ready backpressure, tagged with the requester index. It sits between the client blocks and the shared gate datapath, so the datapath needs no per-client copy.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8
- WIDTH, 8, operand and result width in bits
- IDW, $clog2(NUM_REQ), requester-index width (derived; do not override)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester grant/accept (one-hot or zero)
- req_op  input  NUM_REQ*3  opcode, requester i at [3i+2:3i]
- req_a  input  NUM_REQ*WIDTH  operand A, requester i at [WIDTH*i +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  operand B, same packing
- resp_valid  output  1  response valid
- resp_ready  input  1  response consumer ready
- resp_data  output  WIDTH  result
- resp_id  output  IDW  index of the requester that produced resp_data
- resp_err  output  1  illegal opcode flag
- grant_cnt  output  16  accepted-request count (present only with LGU_ARB_GRANT_CNT_EN)

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 NOT (~a; b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
  - 7 illegal: resp_data=0, resp_err=1.
- Output slot FSM:
  - EMPTY (resp_valid=0) and FULL (resp_valid=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept while resp_ready=1 (back-to-back).
  - FULL→EMPTY when resp_ready=1 and there is no accept.
  - FULL holds while resp_ready=0.
- Slot free = !resp_valid || resp_ready.
- Arbitration:
  - Combinational search for the first requester with req_valid set, starting at pointer rr_ptr and wrapping at NUM_REQ.
  - req_ready[winner]=1 only when the slot is free; all other req_ready bits are 0.
- Accept = req_valid[i] && req_ready[i]. On accept:
  - The result is registered into resp_data/resp_err/resp_id.
  - rr_ptr ← (winner+1) mod NUM_REQ.
- rr_ptr is unchanged when nothing is accepted.
- Requester inputs are sampled only on the accept cycle. A requester may change them freely while not granted.
- Reset values: resp_valid=0, resp_data=0, resp_id=0, resp_err=0, rr_ptr=0, grant_cnt=0.
- req_ready is combinational and is 0 during reset.

## Timing
- Latency: accept in cycle N → resp_valid=1 with the result in cycle N+1.
- Throughput: one request per cycle while resp_ready=1.
- While FULL and resp_ready=0:
  - resp_data, resp_id and resp_err are held stable.
  - All req_ready=0.
- Simultaneous drain and accept: a new result replaces the old one in the same edge, with no bubble.
- Pointer wrap: winner NUM_REQ-1 → rr_ptr=0.
- A lone requester is granted every cycle regardless of rr_ptr.
- Reset asserted mid-operation clears the slot immediately (asynchronously). The in-flight result is discarded, not replayed.
- No combinational path from resp_ready to resp_data. resp_ready→req_ready is combinational by design.

## Configuration
- LGU_ARB_GRANT_CNT_EN defined:
  - Adds the grant_cnt output port.
  - 16-bit counter increments on every accept and saturates at 16'hFFFF.
  - Cleared by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
(NUM_REQ=4, WIDTH=8)
- Reset: assert rst_n=0 mid-stream with resp_valid=1 → resp_valid/resp_data/resp_id/resp_err = 0 immediately; after release the first grant goes to requester 0.
- Single request: requester 2, op=5, a=8'hF0, b=8'h3C, resp_ready=1 → req_ready=4'b0100 that cycle; next cycle resp_data=8'hCC, resp_id=2, resp_err=0.
- Fairness: all four req_valid held high, resp_ready=1 → accepts in consecutive cycles to ids 0,1,2,3,0,1; each response 1 cycle later.
- Backpressure: FULL with resp_data=8'h0F, resp_ready=0 for 3 cycles → data/id stable, req_ready=0; raising resp_ready → next winner accepted the same cycle, new result the following cycle.
- Ops sweep: a=8'hA5, b=8'h0F, ops 0..7 → 05, AF, 5A, FA, 50, AA, 55, then 00 with resp_err=1.
- Counter (LGU_ARB_GRANT_CNT_EN): 10 accepts → grant_cnt=10; with grant_cnt forced to 16'hFFFE, 3 accepts → 16'hFFFF.
